apb_reg_bank: RTL and testbench

Parametrised register bank for the 64-bit APB timer, superseding the fixed single-purpose register block in `counter_control`. It provides a configurable number of word-aligned registers, each with a compile-time access mode: RW (read/write), RO (hardware-driven) or W1C (hardware-set sticky status). It adds byte strobes, registered reads with a valid pulse, and an address-error flag. It sits between the APB slave front-end and the counter/interrupt logic.

---
 rtl/apb_timer_pkg.sv | 45 ++++
 rtl/apb_reg_cell.sv | 79 +++++++
 rtl/apb_reg_bank.sv | 127 ++++++++++++
 tb/tb_apb_reg_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// ---------------------------------------------------------------------------
// apb_timer_pkg
// Shared definitions for the 64-bit APB timer register bank.
//   - acc_mode_e : per-register access mode (RW, RO, W1C)
//   - IDX_*      : register index constants of the timer register map
//   - mode_of()  : derives a register's access mode from the RO/W1C masks
// ---------------------------------------------------------------------------
package apb_timer_pkg;

    typedef enum logic [1:0] {
        ACC_RW  = 2'd0,
        ACC_RO  = 2'd1,
        ACC_W1C = 2'd2
    } acc_mode_e;

    // Widest mask mode_of() can look at; the bank supports up to this many registers.
    localparam int unsigned MAX_REGS = 64;

    // Timer register map (word indices).
    localparam int unsigned IDX_CTRL     = 0;
    localparam int unsigned IDX_LOAD_LO  = 1;
    localparam int unsigned IDX_LOAD_HI  = 2;
    localparam int unsigned IDX_CNT_LO   = 3;
    localparam int unsigned IDX_CNT_HI   = 4;
    localparam int unsigned IDX_CMP_LO   = 5;
    localparam int unsigned IDX_CMP_HI   = 6;
    localparam int unsigned IDX_IRQ_STAT = 7;
    localparam int unsigned TIMER_REGS   = 8;

    // RO takes precedence should a register ever appear in both masks.
    function automatic acc_mode_e mode_of(
        input logic [5:0]          idx,
        input logic [MAX_REGS-1:0] ro_mask,
        input logic [MAX_REGS-1:0] w1c_mask
    );
        if (ro_mask[idx]) begin
            return ACC_RO;
        end
        if (w1c_mask[idx]) begin
            return ACC_W1C;
        end
        return ACC_RW;
    endfunction

endpackage

// File: rtl/apb_reg_cell.sv
// ---------------------------------------------------------------------------
// apb_reg_cell
// One register of the bank with a compile-time access mode.
//   RW  : byte-strobed load from wdata_i
//   RO  : combinational pass-through of hw_ro_val_i (no storage)
//   W1C : sticky bits set by hw_set_i, cleared by writing 1 (set wins)
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   wr_en_i      decoded write hit for this register
//   wdata_i      write data
//   wstrb_i      byte enables
//   hw_ro_val_i  live hardware value (RO mode)
//   hw_set_i     per-bit set pulses (W1C mode)
//   value_o      current register contents
// ---------------------------------------------------------------------------
module apb_reg_cell
    import apb_timer_pkg::*;
#(
    parameter acc_mode_e         MODE    = ACC_RW,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic [DATA_W-1:0]     hw_ro_val_i,
    input  logic [DATA_W-1:0]     hw_set_i,
    output logic [DATA_W-1:0]     value_o
);

    localparam int NB = DATA_W / 8;

    // Per-bit write enable: the byte strobe fanned out over its 8 bits.
    logic [DATA_W-1:0] bit_en;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bit_en
            assign bit_en[gi*8 +: 8] = {8{wr_en_i & wstrb_i[gi]}};
        end
    endgenerate

    // Not every mode uses every input.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, hw_ro_val_i, hw_set_i, wdata_i, bit_en};

    generate
        if (MODE == ACC_RO) begin : g_ro
            assign value_o = hw_ro_val_i;
        end else begin : g_stored
            localparam logic [DATA_W-1:0] RESET_Q = (MODE == ACC_W1C) ? '0 : RST_VAL;

            logic [DATA_W-1:0] value_q;
            logic [DATA_W-1:0] value_d;

            always_comb begin
                value_d = value_q;
                if (MODE == ACC_W1C) begin
                    // Clear first, then OR in the set so a same-cycle set wins.
                    value_d = (value_q & ~(wdata_i & bit_en)) | hw_set_i;
                end else begin
                    value_d = (value_q & ~bit_en) | (wdata_i & bit_en);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value_q <= RESET_Q;
                end else begin
                    value_q <= value_d;
                end
            end

            assign value_o = value_q;
        end
    endgenerate

endmodule

// File: rtl/apb_reg_bank.sv
// ---------------------------------------------------------------------------
// apb_reg_bank
// Parametrised register bank between the APB slave front-end and the timer
// core. Decodes word-aligned accesses, drives one apb_reg_cell per register,
// and registers read data with a valid pulse and an address-error pulse.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   wr_en       write request          rd_en     read request
//   addr        byte address           wdata     write data
//   wstrb       byte enables           hw_ro_val live values of RO registers
//   hw_set      W1C set pulses         rdata     registered read data
//   rd_valid    read data strobe       err       unmapped/misaligned access
//   reg_q       all register contents, flattened (register 0 in the LSBs)
// ---------------------------------------------------------------------------
module apb_reg_bank
    import apb_timer_pkg::*;
#(
    parameter int                           NUM_REGS = 8,
    parameter int                           DATA_W   = 32,
    parameter int                           ADDR_W   = 10,
    parameter logic [NUM_REGS-1:0]          RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0]          W1C_MASK = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]   RST_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic [ADDR_W-1:0]              addr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [DATA_W/8-1:0]            wstrb,
    input  logic [NUM_REGS*DATA_W-1:0]     hw_ro_val,
    input  logic [NUM_REGS*DATA_W-1:0]     hw_set,
    output logic [DATA_W-1:0]              rdata,
    output logic                           rd_valid,
    output logic                           err,
    output logic [NUM_REGS*DATA_W-1:0]     reg_q
);

    localparam int IDX_W = ADDR_W - 2;

    // ---------------- decode ----------------
    logic [IDX_W-1:0] idx;
    logic [31:0]      idx_ext;
    logic             addr_ok;

    assign idx     = addr[ADDR_W-1:2];
    assign idx_ext = 32'(idx);
    // Compare in 32 bits so the range check stays meaningful whatever NUM_REGS is.
    assign addr_ok = (addr[1:0] == 2'b00) && (idx_ext < 32'(NUM_REGS));

    logic [NUM_REGS-1:0]   wr_hit;
    logic [DATA_W-1:0]     reg_word [NUM_REGS];

    // ---------------- register cells ----------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam acc_mode_e CELL_MODE =
                mode_of(6'(gi), MAX_REGS'(RO_MASK), MAX_REGS'(W1C_MASK));

            assign wr_hit[gi] = wr_en && addr_ok && (idx_ext == 32'(gi));

            apb_reg_cell #(
                .MODE    (CELL_MODE),
                .DATA_W  (DATA_W),
                .RST_VAL (RST_VAL[gi*DATA_W +: DATA_W])
            ) u_cell (
                .clk         (clk),
                .rst_n       (rst_n),
                .wr_en_i     (wr_hit[gi]),
                .wdata_i     (wdata),
                .wstrb_i     (wstrb),
                .hw_ro_val_i (hw_ro_val[gi*DATA_W +: DATA_W]),
                .hw_set_i    (hw_set[gi*DATA_W +: DATA_W]),
                .value_o     (reg_word[gi])
            );

            assign reg_q[gi*DATA_W +: DATA_W] = reg_word[gi];
        end
    endgenerate

    // ---------------- read mux ----------------
    // Reads see the cell outputs before the same-edge write lands,
    // so a simultaneous read/write returns the old value.
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_ok && (idx_ext == 32'(i))) begin
                rd_word = reg_word[i];
            end
        end
    end

    // ---------------- response flops ----------------
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q,      err_d;

    always_comb begin
        rdata_d    = rdata_q;
        rd_valid_d = rd_en;
        err_d      = (wr_en || rd_en) && !addr_ok;
        if (rd_en) begin
            // rd_word is already zero for an erroring address.
            rdata_d = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_apb_reg_bank
// Directed-vector bench for apb_reg_bank: reg0 RW (reset 0xFF), reg1 RO,
// reg2 W1C, reg3 RW (reset 0xDEADBEEF), reg4..7 RW.
// ---------------------------------------------------------------------------
module tb_apb_reg_bank;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 10;
    localparam logic [NUM_REGS-1:0] RO_MASK  = 8'b0000_0010;
    localparam logic [NUM_REGS-1:0] W1C_MASK = 8'b0000_0100;
    localparam logic [NUM_REGS*DATA_W-1:0] RST_VAL = {
        32'h0, 32'h0, 32'h0, 32'h0,
        32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0000_00FF
    };

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b1;
    logic                        wr_en = 1'b0;
    logic                        rd_en = 1'b0;
    logic [ADDR_W-1:0]           addr = '0;
    logic [DATA_W-1:0]           wdata = '0;
    logic [DATA_W/8-1:0]         wstrb = '0;
    logic [NUM_REGS*DATA_W-1:0]  hw_ro_val = '0;
    logic [NUM_REGS*DATA_W-1:0]  hw_set = '0;
    logic [DATA_W-1:0]           rdata;
    logic                        rd_valid;
    logic                        err;
    logic [NUM_REGS*DATA_W-1:0]  reg_q;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RO_MASK  (RO_MASK),
        .W1C_MASK (W1C_MASK),
        .RST_VAL  (RST_VAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .hw_ro_val (hw_ro_val),
        .hw_set    (hw_set),
        .rdata     (rdata),
        .rd_valid  (rd_valid),
        .err       (err),
        .reg_q     (reg_q)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return reg_q[i*DATA_W +: DATA_W];
    endfunction

    // One bus cycle: drive after the falling edge, sample 1 ns after the rising edge.
    task automatic bus(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        addr  = a;
        wdata = d;
        wstrb = s;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("bus wr=%0d rd=%0d addr=%03h wdata=%08h wstrb=%h -> rdata=%08h rd_valid=%0d err=%0d",
                 wr, rd, a, d, s, rdata, rd_valid, err);
    endtask

    task automatic idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        hw_ro_val[1*DATA_W +: DATA_W] = 32'h1010_1010;

        // ---- asynchronous reset, checked before any clock edge ----
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_rdata",    rdata,            32'h0);
        check_eq("rst_rd_valid", 32'(rd_valid),    32'h0);
        check_eq("rst_err",      32'(err),         32'h0);
        check_eq("rst_reg0",     reg_of(0),        32'h0000_00FF);
        check_eq("rst_reg1_ro",  reg_of(1),        32'h1010_1010);
        check_eq("rst_reg2_w1c", reg_of(2),        32'h0);
        check_eq("rst_reg3",     reg_of(3),        32'hDEAD_BEEF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- basic write / read ----
        bus(1, 0, 10'h000, 32'hABAB_ABAB, 4'hF);
        check_eq("wr0_reg_q", reg_of(0), 32'hABAB_ABAB);
        check_eq("wr0_err",   32'(err),  32'h0);
        check_eq("wr0_rdata_held", rdata, 32'h0);
        bus(0, 1, 10'h000, 32'h0, 4'h0);
        check_eq("rd0_rdata", rdata,          32'hABAB_ABAB);
        check_eq("rd0_valid", 32'(rd_valid),  32'h1);
        idle();
        check_eq("rd0_valid_pulse", 32'(rd_valid), 32'h0);
        check_eq("rd0_rdata_hold",  rdata,         32'hABAB_ABAB);

        // ---- byte strobes ----
        bus(1, 0, 10'h000, 32'h1234_5678, 4'hF);
        bus(1, 0, 10'h000, 32'hFFFF_FFFF, 4'b0101);
        bus(0, 1, 10'h000, 32'h0, 4'h0);
        check_eq("strb_rdata", rdata, 32'h12FF_56FF);

        // ---- RO register ----
        bus(1, 0, 10'h004, 32'h8888_8888, 4'hF);
        check_eq("ro_wr_err", 32'(err), 32'h0);
        bus(0, 1, 10'h004, 32'h0, 4'h0);
        check_eq("ro_rdata",  rdata,    32'h1010_1010);
        check_eq("ro_rd_err", 32'(err), 32'h0);
        hw_ro_val[1*DATA_W +: DATA_W] = 32'h2020_2020;
        bus(0, 1, 10'h004, 32'h0, 4'h0);
        check_eq("ro_live", rdata, 32'h2020_2020);

        // ---- W1C register ----
        @(negedge clk);
        hw_set[2*DATA_W +: DATA_W] = 32'h0000_0005;
        @(negedge clk);
        hw_set = '0;
        bus(0, 1, 10'h008, 32'h0, 4'h0);
        check_eq("w1c_set", rdata, 32'h5);
        bus(1, 0, 10'h008, 32'h0000_0001, 4'hF);
        bus(0, 1, 10'h008, 32'h0, 4'h0);
        check_eq("w1c_clr1", rdata, 32'h4);
        bus(1, 0, 10'h008, 32'h0000_0000, 4'hF);
        check_eq("w1c_wr0", reg_of(2), 32'h4);
        hw_set[2*DATA_W +: DATA_W] = 32'h0000_0004;
        bus(1, 0, 10'h008, 32'h0000_0004, 4'hF);
        hw_set = '0;
        bus(0, 1, 10'h008, 32'h0, 4'h0);
        check_eq("w1c_set_wins", rdata, 32'h4);
        bus(1, 0, 10'h008, 32'h0000_0004, 4'h0);
        check_eq("w1c_no_strb", reg_of(2), 32'h4);
        bus(1, 0, 10'h008, 32'h0000_0004, 4'h1);
        check_eq("w1c_clr2", reg_of(2), 32'h0);

        // ---- errors ----
        bus(0, 1, 10'h002, 32'h0, 4'h0);
        check_eq("err_rd_flag",  32'(err),      32'h1);
        check_eq("err_rd_valid", 32'(rd_valid), 32'h1);
        check_eq("err_rd_rdata", rdata,         32'h0);
        idle();
        check_eq("err_pulse", 32'(err), 32'h0);
        bus(1, 0, 10'h3FC, 32'hFFFF_FFFF, 4'hF);
        check_eq("err_wr_flag", 32'(err),  32'h1);
        check_eq("err_wr_reg0", reg_of(0), 32'h12FF_56FF);
        check_eq("err_wr_reg3", reg_of(3), 32'hDEAD_BEEF);
        check_eq("err_wr_reg7", reg_of(7), 32'h0);
        bus(1, 0, 10'h001, 32'hFFFF_FFFF, 4'hF);
        check_eq("err_mis_flag", 32'(err),  32'h1);
        check_eq("err_mis_reg0", reg_of(0), 32'h12FF_56FF);
        bus(1, 0, 10'h020, 32'hFFFF_FFFF, 4'hF);
        check_eq("err_idx8_flag", 32'(err), 32'h1);
        bus(1, 0, 10'h01C, 32'hCAFE_F00D, 4'hF);
        check_eq("last_reg_err", 32'(err),  32'h0);
        check_eq("last_reg_q",   reg_of(7), 32'hCAFE_F00D);

        // ---- simultaneous write + read ----
        bus(1, 0, 10'h000, 32'h0000_0001, 4'hF);
        bus(1, 1, 10'h000, 32'h0000_0002, 4'hF);
        check_eq("rw_old_val", rdata, 32'h1);
        bus(0, 1, 10'h000, 32'h0, 4'h0);
        check_eq("rw_new_val", rdata, 32'h2);

        // ---- reset during a write ----
        @(negedge clk);
        wr_en = 1'b1;
        addr  = 10'h000;
        wdata = 32'h5555_5555;
        wstrb = 4'hF;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check_eq("rst_mid_reg0",  reg_of(0), 32'h0000_00FF);
        check_eq("rst_mid_reg7",  reg_of(7), 32'h0);
        check_eq("rst_mid_rdata", rdata,     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus(0, 1, 10'h000, 32'h0, 4'h0);
        check_eq("post_rst_rd", rdata, 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
